// File: rtl/uart_mem_master_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_master_if
// Purpose  : Byte-stream and native memory bus bundle for uart_mem_master.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_mem_master_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        busy;

   modport master (
      input  rx_data, rx_valid, tx_ready, mem_rdata, mem_ready,
      output rx_ready, tx_data, tx_valid, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, mem_rdata, mem_ready,
      input  rx_ready, tx_data, tx_valid, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_master
// Purpose  : Turns 'W'/'R' command byte streams into single-word bus cycles.
// Revision : 1.0 - initial release
// ============================================================================
module uart_mem_master #(
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter logic [7:0] CMD_WRITE      = 8'h57,
   parameter logic [7:0] CMD_READ       = 8'h52
) (
   input  logic              clk,
   input  logic              rst,
   uart_mem_master_if.master bus
);
   localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] c_IDLE      = 3'd0;
   localparam logic [2:0] c_GET_ADDR  = 3'd1;
   localparam logic [2:0] c_GET_DATA  = 3'd2;
   localparam logic [2:0] c_BUS_REQ   = 3'd3;
   localparam logic [2:0] c_WAIT      = 3'd4;
   localparam logic [2:0] c_SEND_RESP = 3'd5;
   localparam logic [2:0] c_GAP       = 3'd6;

   logic [2:0]         r_state;
   logic               r_is_write;
   logic [1:0]         r_cnt;
   logic [23:0]        r_addr;
   logic [29:0]        r_word;
   logic [c_TMO_W-1:0] r_tmo;
   logic [31:0]        r_resp;
   logic [1:0]         r_left;
   logic               r_mem_valid;
   logic [31:0]        r_mem_addr;
   logic [31:0]        r_mem_wdata;
   logic [3:0]         r_mem_wstrb;

   logic w_rx_fire;
   logic w_tx_fire;

   assign bus.rx_ready  = !rst && (r_state == c_IDLE || r_state == c_GET_ADDR ||
                                   r_state == c_GET_DATA);
   assign bus.tx_valid  = (r_state == c_SEND_RESP);
   assign bus.tx_data   = r_resp[31:24];
   assign bus.busy      = (r_state != c_IDLE);
   assign bus.mem_valid = r_mem_valid;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_wstrb = r_mem_wstrb;

   assign w_rx_fire = bus.rx_valid && bus.rx_ready;
   assign w_tx_fire = bus.tx_valid && bus.tx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_IDLE;
         r_is_write  <= 1'b0;
         r_cnt       <= 2'd0;
         r_addr      <= 24'd0;
         r_word      <= 30'd0;
         r_tmo       <= '0;
         r_resp      <= 32'd0;
         r_left      <= 2'd0;
         r_mem_valid <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_mem_wstrb <= 4'd0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_rx_fire) begin
                  if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
                     r_is_write <= (bus.rx_data == CMD_WRITE);
                     r_cnt      <= 2'd0;
                     r_state    <= c_GET_ADDR;
                  end else begin
                     r_resp  <= {8'h3F, 24'd0};
                     r_left  <= 2'd0;
                     r_state <= c_SEND_RESP;
                  end
               end
            end
            c_GET_ADDR: begin
               if (w_rx_fire) begin
                  // Only the word address survives; the last byte's low two bits are dropped.
                  r_addr <= {r_addr[15:0], bus.rx_data};
                  r_cnt  <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     r_word  <= {r_addr, bus.rx_data[7:2]};
                     r_state <= r_is_write ? c_GET_DATA : c_BUS_REQ;
                  end
               end
            end
            c_GET_DATA: begin
               if (w_rx_fire) begin
                  r_mem_wdata <= {r_mem_wdata[23:0], bus.rx_data};
                  r_cnt       <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     r_state <= c_BUS_REQ;
                  end
               end
            end
            c_BUS_REQ: begin
               r_mem_valid <= 1'b1;
               r_mem_addr  <= {r_word, 2'b00};
               r_mem_wstrb <= r_is_write ? 4'hF : 4'h0;
               r_tmo       <= '0;
               r_state     <= c_WAIT;
            end
            c_WAIT: begin
               if (bus.mem_ready) begin
                  r_mem_valid <= 1'b0;
                  r_mem_wstrb <= 4'h0;
                  r_state     <= c_SEND_RESP;
                  if (r_is_write) begin
                     r_resp <= {8'h4B, 24'd0};
                     r_left <= 2'd0;
                  end else begin
                     r_resp <= bus.mem_rdata;
                     r_left <= 2'd3;
                  end
               end else if (r_tmo == c_TMO_LAST) begin
                  r_mem_valid <= 1'b0;
                  r_resp      <= {8'h54, 24'd0};
                  r_left      <= 2'd0;
                  r_state     <= c_SEND_RESP;
               end else begin
                  r_tmo <= r_tmo + c_TMO_W'(1);
               end
            end
            c_SEND_RESP: begin
               if (w_tx_fire) begin
                  if (r_left == 2'd0) begin
                     r_state <= c_GAP;
                  end else begin
                     r_resp <= {r_resp[23:0], 8'd0};
                     r_left <= r_left - 2'd1;
                  end
               end
            end
            c_GAP: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: doc/uart_mem_master.md
Name: uart_mem_master

Overview:
- Byte-stream-to-bus bridge that initiates single-word transactions on the PicoRV32-style native memory interface (mem_valid/mem_ready).
- Takes command bytes from the UART RX path and returns response bytes to the UART TX path.
- Lets a host load program RAM, poke the FIFO/CTRL registers and read back memory without the CPU.
- Sits between the UART byte FIFOs and the memory/IO responder, muxed with the CPU bus by top-level logic using busy.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles to wait for mem_ready before aborting; must be >= 2.
CMD_WRITE, 8'h57, command byte for word write ('W').
CMD_READ, 8'h52, command byte for word read ('R').

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rx_data  in  8  incoming command byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  bridge accepts rx_data this cycle
tx_data  out  8  response byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  downstream accepts tx_data this cycle
mem_valid  out  1  bus request
mem_addr  out  32  word address, bits [1:0] always 0
mem_wdata  out  32  write data
mem_wstrb  out  4  4'hF for write, 4'h0 for read
mem_rdata  in  32  read data from responder
mem_ready  in  1  responder completion
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 on a clk edge): state IDLE. rx_ready=0 for that cycle, tx_valid=0, tx_data=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0. Any partial command, pending bus request or pending response is discarded. Reset mid-transaction drops mem_valid on the same edge.
- Handshakes:
  - A byte is accepted on an edge where rx_valid && rx_ready.
  - A response byte is transferred on an edge where tx_valid && tx_ready. tx_data is held stable while tx_valid && !tx_ready.
- rx_ready is registered-free (combinational from state): 1 in IDLE, GET_ADDR and GET_DATA only.
- States:
  - IDLE:
    - Accept cmd byte.
    - CMD_WRITE or CMD_READ: latch the type, clear byte counter, go GET_ADDR.
    - Any other value: load response 8'h3F ('?'), go SEND_RESP.
  - GET_ADDR:
    - Accept 4 bytes, big-endian (first byte = addr[31:24]).
    - After the 4th byte: write goes GET_DATA; read goes BUS_REQ.
  - GET_DATA:
    - Accept 4 bytes, big-endian, into mem_wdata.
    - After the 4th byte, go BUS_REQ.
  - BUS_REQ (one cycle):
    - Assert mem_valid=1 with mem_addr={addr[31:2],2'b00}.
    - Set mem_wstrb=4'hF for write, 4'h0 for read.
    - Clear the timeout counter and go WAIT.
  - WAIT:
    - mem_valid, mem_addr, mem_wdata and mem_wstrb are held stable.
    - Edge with mem_ready=1:
      - mem_valid<=0 and mem_wstrb<=0.
      - Read: capture mem_rdata into a response shift register; the response is 4 bytes, MSB first.
      - Write: the response is the single byte 8'h4B ('K').
      - Go SEND_RESP.
    - Counter reaches TIMEOUT_CYCLES-1 without mem_ready: mem_valid<=0, response 8'h54 ('T'), go SEND_RESP.
    - mem_ready and timeout on the same edge: mem_ready wins.
  - SEND_RESP:
    - tx_valid=1 presenting the current byte.
    - On each transfer, advance to the next byte.
    - After the last byte: tx_valid<=0, go GAP.
  - GAP (one cycle): no bus or byte activity, then IDLE. This guarantees mem_valid is low for at least 2 cycles between transactions.
- mem_ready is ignored in every state except WAIT.
- rx bytes arriving in BUS_REQ, WAIT, SEND_RESP or GAP are not accepted (rx_ready=0) and remain pending upstream.
- No inter-byte timeout: a partial command waits indefinitely until completed or reset.
- Latency: mem_valid rises on the edge after the last command byte is accepted. The first response byte is valid the cycle after mem_ready is sampled.
- Timeout counter width is $clog2(TIMEOUT_CYCLES)+1 bits. The counter saturates and does not wrap.

Test Plan:
- Write: rx 57 00 00 00 10 DE AD BE EF; responder asserts ready 1 cycle after valid -> one request with mem_addr=0x00000010, mem_wdata=0xDEADBEEF, mem_wstrb=F, mem_valid high exactly 2 cycles; tx 4B.
- Read: preload responder word 0x30000000 = 0x00000002; rx 52 30 00 00 00 -> mem_wstrb=0, tx 00 00 00 02 in order.
- Unaligned and bad command: rx 52 00 00 00 13 -> mem_addr=0x00000010. rx 41 -> tx 3F, no mem_valid, back in IDLE.
- Timeout: TIMEOUT_CYCLES=16, responder never readies -> mem_valid high 16 cycles then low, tx 54; a late mem_ready afterwards is ignored.
- Backpressure: read returning 0x11223344 with tx_ready toggling 1-of-3 cycles -> tx_data stable while stalled, bytes 11 22 33 44 each transferred once; rx_ready=0 throughout.
- Reset mid-op: rst during WAIT, and again after 2 address bytes -> all outputs 0 next cycle; a following complete write command executes normally.
